// File: rtl/pipe_collect.sv
// Result-collection stage for the fixed-latency f = ((a+b)+(c-d))*d pipeline:
// issue credits, a LAT-deep valid delay line and a show-ahead result FIFO.
module pipe_collect #(
  parameter int N     = 10,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [N-1:0]           pipe_f,
  output logic [N-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] out_count,
  output logic [15:0]            done_cnt,
  output logic                   ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic            issue_fire;
  logic            capture;
  logic            out_fire;
  logic            push;
  logic            full;
  logic            empty;
  logic [LAT-1:0]  vld_reg;
  logic [LAT-1:0]  vld_next;
  logic [CW-1:0]   inflight_reg;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [CW:0]     credit_used;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [15:0]     done_cnt_reg;
  logic            ovf_err_reg;
  logic [N-1:0]    mem [DEPTH];

  // Credits cover both stored results and results still inside the pipeline,
  // so a granted issue always has a FIFO slot waiting for it.
  assign credit_used = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign issue_ready = credit_used < {1'b0, DEPTH_C};
  assign issue_fire  = issue_valid & issue_ready;

  assign capture   = vld_reg[LAT-1];
  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign out_valid = ~empty;
  assign out_fire  = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = capture & (~full | out_fire);

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_next[gi] = issue_fire;
      end else begin : g_tail
        assign vld_next[gi] = vld_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, out_fire})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    inflight_next = inflight_reg;
    case ({issue_fire, capture})
      2'b10:   inflight_next = inflight_reg + CW'(1);
      2'b01:   inflight_next = inflight_reg - CW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg      <= '0;
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      done_cnt_reg <= '0;
      ovf_err_reg  <= 1'b0;
    end else begin
      vld_reg      <= vld_next;
      inflight_reg <= inflight_next;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (out_fire) begin
        rd_ptr_reg   <= rd_ptr_reg + PW'(1);
        done_cnt_reg <= done_cnt_reg + 16'd1;
      end
      if (capture && !push) begin
        ovf_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg] <= pipe_f;
    end
  end

  assign out_data  = empty ? '0 : mem[rd_ptr_reg];
  assign out_count = count_reg;
  assign done_cnt  = done_cnt_reg;
  assign ovf_err   = ovf_err_reg;

endmodule

// File: tb/tb_pipe_collect.sv
// Directed bench for pipe_collect: models the arithmetic pipeline and checks
// FIFO output order against a scoreboard of issued operations.
module tb_pipe_collect;

  localparam int N     = 10;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic         clk;
  logic         rst_n;
  logic         issue_valid;
  logic         issue_ready;
  logic [N-1:0] pipe_f;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_count;
  logic [15:0]  done_cnt;
  logic         ovf_err;

  logic [N-1:0] op_a, op_b, op_c, op_d;
  logic [N-1:0] st [LAT];
  logic [N-1:0] exp_q [$];
  int           n_cmp;
  int           n_err;
  int           n_fire;
  int           done_exp;

  pipe_collect #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_f      (pipe_f),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .done_cnt    (done_cnt),
    .ovf_err     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] f_model(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] t;
    t = a + b + (c - d);
    return t * d;
  endfunction

  // Free-running pipeline: operand sample plus LAT-1 further register stages.
  always @(posedge clk) begin
    st[0] <= f_model(op_a, op_b, op_c, op_d);
    for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
  end
  assign pipe_f = st[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    op_a = N'($urandom);
    op_b = N'($urandom);
    op_c = N'($urandom);
    op_d = N'($urandom);
  endtask

  // One clock: score the output handshake and any issue, then advance.
  task automatic tick();
    logic [N-1:0] e;
    #3;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_output", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        $display("out #%0d data=%0d expected=%0d", done_exp, out_data, e);
        chk("sb_data", 32'(out_data), 32'(e));
      end
      done_exp++;
    end
    if (issue_valid && issue_ready) begin
      exp_q.push_back(f_model(op_a, op_b, op_c, op_d));
      n_fire++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    done_exp = 0;
  endtask

  // Hold issue_valid with no drain: the credits must admit exactly DEPTH ops.
  task automatic fill();
    int start;
    start = n_fire;
    out_ready   = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rand_ops();
      tick();
    end
    chk("fill_fires", 32'(n_fire - start), 32'd8);
    chk("fill_ready_low", 32'(issue_ready), 32'd0);
    chk("fill_count_7", 32'(out_count), 32'd7);
    issue_valid = 1'b0;
    tick();
    chk("fill_count_8", 32'(out_count), 32'd8);
    chk("fill_ovf", 32'(ovf_err), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    n_cmp = 0; n_err = 0; n_fire = 0; done_exp = 0;
    rst_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_c = '0; op_d = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;

    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);

    // Single op with exact latency
    op_a = 10'd3; op_b = 10'd4; op_c = 10'd10; op_d = 10'd2;
    out_ready = 1'b1; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    repeat (3) tick();
    chk("lat_not_early", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'd30);
    tick();
    chk("single_one_cycle", 32'(out_valid), 32'd0);
    chk("single_done", 32'(done_cnt), 32'd1);

    // Modulo arithmetic is passed through unchanged
    op_a = 10'd1000; op_b = 10'd20; op_c = 10'd1023; op_d = 10'd3;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    wait_valid();
    chk("wrap_data", 32'(out_data), 32'd1000);
    tick();

    // Backpressure and credit release
    fill();
    out_ready = 1'b1;
    tick();
    chk("ready_after_first_pop", 32'(issue_ready), 32'd1);
    repeat (7) tick();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_done", 32'(done_cnt), 32'(done_exp));

    // Simultaneous push and pop at full (extra op admitted by force)
    fill();
    force dut.issue_ready = 1'b1;
    issue_valid = 1'b1;
    rand_ops();
    tick();
    issue_valid = 1'b0;
    release dut.issue_ready;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    chk("full_pushpop_count", 32'(out_count), 32'd8);
    chk("full_pushpop_ovf", 32'(ovf_err), 32'd0);
    repeat (8) tick();
    chk("full_pushpop_empty", 32'(out_valid), 32'd0);
    chk("full_pushpop_done", 32'(done_cnt), 32'(done_exp));

    // Reset with operations in flight
    issue_valid = 1'b1;
    repeat (3) begin rand_ops(); tick(); end
    issue_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    done_exp = 0;
    saw_valid = 1'b0;
    repeat (7) begin tick(); saw_valid |= out_valid; end
    chk("midrst_no_valid", 32'(saw_valid), 32'd0);
    chk("midrst_inflight", 32'(dut.inflight_reg), 32'd0);
    chk("midrst_ready", 32'(issue_ready), 32'd1);
    chk("midrst_done", 32'(done_cnt), 32'd0);

    // Forced overflow: ninth capture is dropped
    out_ready = 1'b0;
    force dut.issue_ready = 1'b1;
    issue_valid = 1'b1;
    repeat (9) begin rand_ops(); tick(); end
    issue_valid = 1'b0;
    release dut.issue_ready;
    repeat (5) tick();
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_count", 32'(out_count), 32'd8);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("ovf_drained", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    out_ready = 1'b0;
    do_reset();
    chk("ovf_cleared", 32'(ovf_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
